spike_tx_ni: RTL and testbench
==============================

SPIKE_TX_NI -- requirements
Module: spike_tx_ni

Interface
REQ-001 SHALL have parameter ROWS, default 3, mesh row count.
REQ-002 SHALL have parameter COLS, default 3, mesh column count.
REQ-003 SHALL have parameter NUM_NEURONS, default 4, neurons per node (max 256).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, flit width (fixed at 32 for this format).
REQ-005 SHALL have parameters NODE_X, default 0, and NODE_Y, default 0, giving this node's mesh coordinates.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset (rst=0 resets).
REQ-008 SHALL have port spike_in_valid  input  1  spike vector offered by neuron core.
REQ-009 SHALL have port spike_in_vec  input  NUM_NEURONS  bit i set = neuron i fired.
REQ-010 SHALL have port spike_in_ready  output  1  vector accepted when valid&&ready.
REQ-011 SHALL have ports cfg_we  input  1, cfg_addr  input  8, cfg_dest_x  input  4, cfg_dest_y  input  4, cfg_en  input  1  destination-table write.
REQ-012 SHALL have port pkt_valid  output  1  flit offered to router local input port.
REQ-013 SHALL have port pkt_data  output  DATA_WIDTH  flit.
REQ-014 SHALL have port pkt_ready  input  1  router accepts flit when valid&&ready.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Flit format SHALL be [31:28] dest_x, [27:24] dest_y, [23:20] NODE_X, [19:16] NODE_Y, [15:8] neuron id, [7:0] timestep.
REQ-017 Destination table SHALL hold NUM_NEURONS entries {en, dest_x, dest_y}; cfg_we writes entry cfg_addr at the clock edge; writes with cfg_addr>=NUM_NEURONS are ignored; writes are legal in any state.
REQ-018 FSM SHALL have states IDLE, SCAN, SEND.
REQ-019 spike_in_ready SHALL be 1 only in IDLE; on handshake, vector loads a pending mask, current timestep counter value is latched as packet timestep, counter increments (mod 256, 255->0), state -> SCAN.
REQ-020 SCAN: mask empty -> IDLE; else select lowest set bit i; entry i disabled -> clear bit i, stay SCAN; entry i enabled -> register flit, clear bit i, -> SEND.
REQ-021 SEND: pkt_valid=1 with pkt_data held stable until pkt_ready=1; on handshake -> SCAN.
REQ-022 Minimum latency: vector accepted at edge N -> pkt_valid high after edge N+1; one flit per 2 cycles at best.
REQ-023 Table writes during SEND SHALL NOT alter the held flit; they affect later SCAN cycles only.
REQ-024 All-zero vector SHALL be accepted, increment timestep, pass one SCAN cycle, return IDLE, emit nothing.
REQ-025 pkt_valid SHALL never deassert without handshake except by reset.

Reset
REQ-026 On rst=0 at an edge: state IDLE, pending mask 0, timestep counter 0, all table entries disabled (dest 0,0), pkt_valid 0, pkt_data 0; spike_in_ready and busy follow the IDLE state (ready 1, busy 0) once rst=1.
REQ-027 Reset mid-SEND SHALL drop the flit and remaining mask; pkt_valid 0 in the cycle following the reset edge.

Structure
REQ-028 Flit field offsets/widths SHALL live in the shared NoC defines header, reused by router and receiver NI.
REQ-029 Lowest-set-bit selection SHALL be one sub-module, lsb_priority_enc (vector in, index and found out, combinational).

Verification (NODE_X=1, NODE_Y=1, NUM_NEURONS=4)
REQ-030 Reset held 3 cycles -> pkt_valid=0, pkt_data=0, busy=0, spike_in_ready=1 after release.
REQ-031 Enable n0->(2,0), n2->(0,2); vector 4'b0101, pkt_ready=1 -> flits 0x20110000 then 0x02110200, then IDLE.
REQ-032 Same setup, pkt_ready=0 for 5 cycles during first flit -> pkt_valid stays 1, pkt_data stays 0x20110000, spike_in_ready stays 0.
REQ-033 Only n3 enabled to (2,2); vector 4'b1111 -> exactly one flit 0x22110300.
REQ-034 257 all-zero-then-one vectors: vector #257 = 4'b0001 with n0 enabled to (0,0) -> flit 0x00110000 (timestep wrapped to 0).
REQ-035 Assert rst=0 while in SEND -> next cycle pkt_valid=0, table cleared; vector 4'b0001 afterwards -> no flit emitted.

Source files
------------

// File: rtl/spike_tx_ni_pkg.sv
// Shared NoC spike-flit definitions: field placement, FSM states and the
// destination-table entry, reused by the router and the receiving NI.
package spike_tx_ni_pkg;

  localparam int FLIT_W     = 32;
  localparam int COORD_W    = 4;
  localparam int ID_W       = 8;
  localparam int TS_W       = 8;
  localparam int CFG_ADDR_W = 8;

  localparam int DST_X_LSB  = 28;
  localparam int DST_Y_LSB  = 24;
  localparam int SRC_X_LSB  = 20;
  localparam int SRC_Y_LSB  = 16;
  localparam int ID_LSB     = 8;
  localparam int TS_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
  } dest_entry_t;

  function automatic logic [FLIT_W-1:0] pack_flit(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [ID_W-1:0]    neuron_id,
    input logic [TS_W-1:0]    timestep
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[DST_X_LSB +: COORD_W] = dest_x;
    f[DST_Y_LSB +: COORD_W] = dest_y;
    f[SRC_X_LSB +: COORD_W] = src_x;
    f[SRC_Y_LSB +: COORD_W] = src_y;
    f[ID_LSB    +: ID_W]    = neuron_id;
    f[TS_LSB    +: TS_W]    = timestep;
    return f;
  endfunction

endpackage

// File: rtl/spike_tx_ni_if.sv
// Spike-input, destination-config and router-facing flit signals of the
// transmit NI; the slave modport is the NI itself.
interface spike_tx_ni_if
  import spike_tx_ni_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = 32
);

  logic                   spike_in_valid;
  logic [NUM_NEURONS-1:0] spike_in_vec;
  logic                   spike_in_ready;

  logic                   cfg_we;
  logic [CFG_ADDR_W-1:0]  cfg_addr;
  logic [COORD_W-1:0]     cfg_dest_x;
  logic [COORD_W-1:0]     cfg_dest_y;
  logic                   cfg_en;

  logic                   pkt_valid;
  logic [DATA_WIDTH-1:0]  pkt_data;
  logic                   pkt_ready;

  logic                   busy;

  modport master (
    output spike_in_valid, spike_in_vec,
    output cfg_we, cfg_addr, cfg_dest_x, cfg_dest_y, cfg_en,
    output pkt_ready,
    input  spike_in_ready, pkt_valid, pkt_data, busy
  );

  modport slave (
    input  spike_in_valid, spike_in_vec,
    input  cfg_we, cfg_addr, cfg_dest_x, cfg_dest_y, cfg_en,
    input  pkt_ready,
    output spike_in_ready, pkt_valid, pkt_data, busy
  );

endinterface

// File: rtl/spike_tx_ni_lsb_priority_enc.sv
// Combinational lowest-set-bit finder: index of the lowest 1 in the vector
// and a flag telling whether any bit was set.
module lsb_priority_enc #(
  parameter int W     = 4,
  parameter int IDX_W = 2
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Walk from the top so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_tx_ni.sv
// Spike transmit network interface: turns a fired-neuron vector into one
// flit per enabled neuron, lowest neuron first, tagged with a timestep.
module spike_tx_ni
  import spike_tx_ni_pkg::*;
#(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int NODE_X      = 0,
  parameter int NODE_Y      = 0
) (
  input  logic         clk,
  input  logic         rst,
  spike_tx_ni_if.slave bus
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  if (DATA_WIDTH != FLIT_W) begin : g_bad_width
    $error("spike_tx_ni: DATA_WIDTH must be 32");
  end
  if (NUM_NEURONS < 1 || NUM_NEURONS > 256) begin : g_bad_neurons
    $error("spike_tx_ni: NUM_NEURONS must be 1..256");
  end
  if (NODE_X >= COLS || NODE_Y >= ROWS) begin : g_bad_coord
    $error("spike_tx_ni: node coordinates outside the mesh");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [NUM_NEURONS-1:0] r_mask;
  logic [TS_W-1:0]        r_ts;
  logic [TS_W-1:0]        r_pkt_ts;
  logic [FLIT_W-1:0]      r_flit;
  dest_entry_t            r_tab [NUM_NEURONS];

  logic [IDX_W-1:0]       w_idx;
  logic                   w_found;
  dest_entry_t            w_sel;
  logic                   w_cfg_hit;

  lsb_priority_enc #(
    .W     (NUM_NEURONS),
    .IDX_W (IDX_W)
  ) u_lsb_enc (
    .i_vec   (r_mask),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_sel     = r_tab[w_idx];
  assign w_cfg_hit = bus.cfg_we && (32'(bus.cfg_addr) < 32'(NUM_NEURONS));
  assign bus.pkt_data = r_flit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next             = r_state;
    bus.spike_in_ready = 1'b0;
    bus.pkt_valid      = 1'b0;
    bus.busy           = 1'b1;
    unique case (r_state)
      IDLE: begin
        bus.spike_in_ready = 1'b1;
        bus.busy           = 1'b0;
        if (bus.spike_in_valid) w_next = SCAN;
      end
      SCAN: begin
        if (!w_found)      w_next = IDLE;
        else if (w_sel.en) w_next = SEND;
      end
      SEND: begin
        bus.pkt_valid = 1'b1;
        if (bus.pkt_ready) w_next = SCAN;
      end
      default: w_next = IDLE;
    endcase
  end

  // The flit is captured in SCAN and only rewritten there, so table writes
  // while a flit waits in SEND cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask   <= '0;
      r_ts     <= '0;
      r_pkt_ts <= '0;
      r_flit   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.spike_in_valid) begin
            r_mask   <= bus.spike_in_vec;
            r_pkt_ts <= r_ts;
            r_ts     <= r_ts + 1'b1;
          end
        end
        SCAN: begin
          if (w_found) begin
            r_mask[w_idx] <= 1'b0;
            if (w_sel.en) begin
              r_flit <= pack_flit(w_sel.dest_x, w_sel.dest_y,
                                  COORD_W'(NODE_X), COORD_W'(NODE_Y),
                                  ID_W'(w_idx), r_pkt_ts);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_tab[i] <= '0;
      end
    end else if (w_cfg_hit) begin
      r_tab[bus.cfg_addr[IDX_W-1:0]] <= '{en:     bus.cfg_en,
                                          dest_x: bus.cfg_dest_x,
                                          dest_y: bus.cfg_dest_y};
    end
  end

endmodule

// File: tb/tb_spike_tx_ni.sv
// Bench for spike_tx_ni: directed scenarios plus randomized vectors and
// table contents, checked against a per-vector flit list model.
module tb_spike_tx_ni;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spike_tx_ni_if #(.NUM_NEURONS(N), .DATA_WIDTH(32)) bus ();

  spike_tx_ni #(
    .ROWS(3), .COLS(3), .NUM_NEURONS(N), .DATA_WIDTH(32), .NODE_X(1), .NODE_Y(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: destination table, timestep and expected flit list.
  typedef struct { bit en; bit [3:0] x; bit [3:0] y; } ent_t;
  ent_t        m_tab [N];
  int          m_ts;
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_tab[i] = '{en: 1'b0, x: 4'd0, y: 4'd0};
    m_ts = 0;
  endfunction

  function automatic void model_vec(input logic [N-1:0] vec);
    for (int i = 0; i < N; i++) begin
      if (vec[i] && m_tab[i].en)
        exp_q.push_back({m_tab[i].x, m_tab[i].y, 4'd1, 4'd1, 8'(i), 8'(m_ts)});
    end
    m_ts = (m_ts + 1) % 256;
  endfunction

  function automatic logic [31:0] obs_at(input int i);
    return (obs_q.size() > i) ? obs_q[i] : 32'hDEAD_DEAD;
  endfunction

  // pkt_ready driver: fixed level or random back-pressure.
  bit rdy_rand  = 1'b0;
  bit rdy_fixed = 1'b1;
  initial begin
    bus.pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.pkt_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // Flit monitor and hold-stability check between handshakes.
  logic        prev_rst = 1'b0;
  logic        prev_vld = 1'b0;
  logic        prev_hs  = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst && prev_rst && prev_vld && !prev_hs) begin
      chk("hold_valid", {31'd0, bus.pkt_valid}, 32'd1);
      chk("hold_data", bus.pkt_data, prev_data);
    end
    if (rst && bus.pkt_valid && bus.pkt_ready) obs_q.push_back(bus.pkt_data);
    prev_rst  = rst;
    prev_vld  = bus.pkt_valid;
    prev_hs   = bus.pkt_valid && bus.pkt_ready;
    prev_data = bus.pkt_data;
  end

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic cfg_write(input int addr, input bit en, input bit [3:0] x, input bit [3:0] y);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 8'(addr);
    bus.cfg_en     = en;
    bus.cfg_dest_x = x;
    bus.cfg_dest_y = y;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    if (addr < N) m_tab[addr] = '{en: en, x: x, y: y};
  endtask

  task automatic send_vec(input logic [N-1:0] vec);
    int k = 0;
    @(negedge clk);
    while (!bus.spike_in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'd0, bus.spike_in_ready}, 32'd1);
    bus.spike_in_valid = 1'b1;
    bus.spike_in_vec   = vec;
    @(posedge clk);
    #1;
    bus.spike_in_valid = 1'b0;
    model_vec(vec);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic wait_valid();
    int k = 0;
    @(negedge clk);
    while (!bus.pkt_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("valid_wait", {31'd0, bus.pkt_valid}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    wait_idle();
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.spike_in_valid = 1'b0;
    bus.spike_in_vec   = '0;
    bus.cfg_we         = 1'b0;
    bus.cfg_addr       = '0;
    bus.cfg_en         = 1'b0;
    bus.cfg_dest_x     = '0;
    bus.cfg_dest_y     = '0;

    do_reset(3);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.pkt_valid}, 32'd0);
    chk("rst_data", bus.pkt_data, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.spike_in_ready}, 32'd1);

    // Two enabled neurons, free-flowing router, first-flit latency.
    cfg_write(0, 1, 4'd2, 4'd0);
    cfg_write(2, 1, 4'd0, 4'd2);
    send_vec(4'b0101);
    @(negedge clk);
    chk("lat_scan", {31'd0, bus.pkt_valid}, 32'd0);
    @(negedge clk);
    chk("lat_send", {31'd0, bus.pkt_valid}, 32'd1);
    wait_idle();
    chk("pair_f0", obs_at(0), 32'h2011_0000);
    chk("pair_f1", obs_at(1), 32'h0211_0200);
    chk("pair_ready", {31'd0, bus.spike_in_ready}, 32'd1);
    drain("pair");

    // Back-pressure for 5 cycles on the first flit.
    do_reset(2);
    cfg_write(0, 1, 4'd2, 4'd0);
    cfg_write(2, 1, 4'd0, 4'd2);
    rdy_fixed = 1'b0;
    send_vec(4'b0101);
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, bus.pkt_valid}, 32'd1);
      chk("bp_data", bus.pkt_data, 32'h2011_0000);
      chk("bp_ready", {31'd0, bus.spike_in_ready}, 32'd0);
    end
    rdy_fixed = 1'b1;
    drain("bp");

    // Table rewrites while a flit is held only affect later scans.
    do_reset(2);
    cfg_write(0, 1, 4'd2, 4'd0);
    cfg_write(1, 1, 4'd1, 4'd1);
    rdy_fixed = 1'b0;
    send_vec(4'b0011);
    wait_valid();
    cfg_write(0, 1, 4'd3, 4'd3);
    cfg_write(1, 0, 4'd1, 4'd1);
    @(negedge clk);
    chk("wr_hold", bus.pkt_data, 32'h2011_0000);
    rdy_fixed = 1'b1;
    wait_idle();
    chk("wr_count", 32'(obs_q.size()), 32'd1);
    chk("wr_f0", obs_at(0), 32'h2011_0000);
    obs_q.delete();
    exp_q.delete();
    send_vec(4'b0011);
    wait_idle();
    chk("wr_after", obs_at(0), 32'h3311_0001);
    drain("wr_next");

    // Only the highest neuron enabled, all neurons fire.
    do_reset(2);
    cfg_write(3, 1, 4'd2, 4'd2);
    send_vec(4'b1111);
    wait_idle();
    chk("only3_count", 32'(obs_q.size()), 32'd1);
    chk("only3_f0", obs_at(0), 32'h2211_0300);
    drain("only3");

    // Empty vectors and timestep wrap.
    do_reset(2);
    cfg_write(0, 1, 4'd0, 4'd0);
    send_vec('0);
    @(negedge clk);
    chk("zero_scan_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("zero_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("zero_idle_ready", {31'd0, bus.spike_in_ready}, 32'd1);
    for (int v = 1; v < 256; v++) send_vec('0);
    send_vec(4'b0001);
    wait_idle();
    chk("wrap_count", 32'(obs_q.size()), 32'd1);
    chk("wrap_f0", obs_at(0), 32'h0011_0000);
    drain("wrap");

    // Reset while a flit is held drops it and clears the table.
    do_reset(2);
    cfg_write(0, 1, 4'd2, 4'd0);
    cfg_write(2, 1, 4'd0, 4'd2);
    rdy_fixed = 1'b0;
    send_vec(4'b0101);
    wait_valid();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.pkt_valid}, 32'd0);
    chk("mid_rst_data", bus.pkt_data, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    rdy_fixed = 1'b1;
    send_vec(4'b0001);
    wait_idle();
    chk("mid_rst_none", 32'(obs_q.size()), 32'd0);
    drain("mid_rst");

    // Random tables, vectors and back-pressure, incl. out-of-range writes.
    do_reset(2);
    for (int i = 0; i < N; i++)
      cfg_write(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    rdy_rand = 1'b1;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      send_vec(N'($urandom_range(0, (1 << N) - 1)));
      drain("rand");
    end
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
